// File: rtl/apb_read_master.sv
// APB read-only burst master: issues `count` reads starting at `base_addr`,
// stepping by ADDR_STEP, with a per-transfer PREADY timeout that aborts the burst.
module apb_read_master #(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  count,
    input  logic        PREADY,
    input  logic [31:0] PRDATA1,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PRWADDR,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  fsm_state
);

    localparam int WW = $clog2(TIMEOUT + 1);

    // Handshake: a transfer completes on the rising edge where PSEL, PENABLE
    // and PREADY are all 1; rd_valid follows one cycle later with the word.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      remaining;
    logic [WW-1:0]   wait_cnt;
    logic            accept;
    logic            xfer_done;
    logic            timed_out;

    always_comb begin
        state_nxt = state;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        accept    = 1'b0;
        xfer_done = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && count != 8'd0) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    xfer_done = 1'b1;
                    state_nxt = (remaining > 8'd1) ? SETUP : FINISH;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    // This cycle is the TIMEOUT-th ACCESS cycle without PREADY.
                    timed_out = 1'b1;
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state     <= IDLE;
            PRWADDR   <= 32'd0;
            rd_data   <= 32'd0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            remaining <= 8'd0;
            wait_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            rd_valid <= xfer_done;
            if (accept) begin
                PRWADDR   <= base_addr;
                remaining <= count;
                err       <= 1'b0;
            end
            if (state == SETUP) begin
                wait_cnt <= '0;
            end
            if (state == ACCESS && !PREADY) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            if (xfer_done) begin
                rd_data   <= PRDATA1;
                PRWADDR   <= PRWADDR + 32'(ADDR_STEP);
                remaining <= remaining - 8'd1;
            end
            if (timed_out) begin
                err <= 1'b1;
            end
        end
    end

    assign PWRITE    = 1'b0;
    assign fsm_state = state;

endmodule

// File: tb/tb_apb_read_master.sv
// Bench for apb_read_master: memory-backed APB slave with scripted wait states,
// a burst-level reference model and an expected-data queue.
module tb_apb_read_master;

    localparam int unsigned ADDR_STEP = 4;
    localparam int unsigned TIMEOUT   = 16;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [7:0]  count = 8'd0;
    logic        PREADY = 1'b0;
    logic [31:0] PRDATA1 = 32'd0;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PRWADDR, rd_data;
    logic        rd_valid, busy, done, err;
    logic [1:0]  fsm_state;

    apb_read_master #(.ADDR_STEP(ADDR_STEP), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .start(start), .base_addr(base_addr),
        .count(count), .PREADY(PREADY), .PRDATA1(PRDATA1), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PRWADDR(PRWADDR), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
        .fsm_state(fsm_state)
    );

    // Clock and watchdog.
    always #5 PCLK = ~PCLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    int waits [256];
    int stall_at = -1;
    int xfer_idx = 0;
    int cur_wait = 0;
    int wait_ctr = 0;
    bit cur_stall = 1'b0;
    int rd_valid_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic slave_write(input logic [31:0] a, input logic [31:0] d);
        mem[a] = d;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 256; i++) waits[i] = 0;
        stall_at = -1;
    endtask

    // Slave and monitor share one process so PREADY is settled before sampling.
    initial forever begin
        @(negedge PCLK);
        if (PSEL && !PENABLE) begin
            cur_wait  = waits[xfer_idx];
            cur_stall = (xfer_idx == stall_at);
            wait_ctr  = 0;
            PREADY    = 1'b0;
        end else if (PSEL && PENABLE) begin
            if (cur_stall) PREADY = 1'b0;
            else if (wait_ctr >= cur_wait) PREADY = 1'b1;
            else begin
                PREADY = 1'b0;
                wait_ctr++;
            end
        end else begin
            PREADY = 1'b0;
        end
        PRDATA1 = mem_read(PRWADDR);

        check("penable_needs_psel", {31'd0, PENABLE & ~PSEL}, 32'd0);
        check("pwrite_low", {31'd0, PWRITE}, 32'd0);
        if (PSEL && PENABLE && exp_addr_q.size() > 0) check("prwaddr", PRWADDR, exp_addr_q[0]);
        if (PSEL && PENABLE && PREADY) begin
            if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
            xfer_idx++;
        end
        if (rd_valid) begin
            rd_valid_cnt++;
            if (exp_q.size() == 0) check("rd_valid_unexpected", 32'd1, 32'd0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end
        if (done) done_cnt++;
    end

    // Burst-level reference: addresses, data words and cycle count from the read plan.
    task automatic model_burst(input logic [31:0] base, input int cnt,
                               output int exp_cycles, output int n_ok, output bit timeout);
        logic [31:0] a;
        exp_q.delete();
        exp_addr_q.delete();
        xfer_idx   = 0;
        exp_cycles = 0;
        timeout    = (stall_at >= 0) && (stall_at < cnt);
        n_ok       = timeout ? stall_at : cnt;
        for (int i = 0; i < n_ok; i++) begin
            a = base + 32'(i) * ADDR_STEP;
            exp_addr_q.push_back(a);
            exp_q.push_back(mem_read(a));
            exp_cycles += 2 + waits[i];
        end
        if (timeout) begin
            exp_addr_q.push_back(base + 32'(n_ok) * ADDR_STEP);
            exp_cycles += 1 + int'(TIMEOUT);
        end
    endtask

    task automatic run_burst(input logic [31:0] base, input int cnt, input bit poke_busy);
        int exp_cycles, n_ok, cycles, rv0, dn0;
        bit timeout;
        model_burst(base, cnt, exp_cycles, n_ok, timeout);
        rv0 = rd_valid_cnt;
        dn0 = done_cnt;
        cycles = 0;
        @(negedge PCLK);
        start = 1'b1; base_addr = base; count = cnt[7:0];
        @(negedge PCLK);
        start = 1'b0; base_addr = $urandom; count = 8'($urandom);
        check("setup_psel", {31'd0, PSEL}, 32'd1);
        check("setup_penable", {31'd0, PENABLE}, 32'd0);
        check("setup_busy", {31'd0, busy}, 32'd1);
        check("err_cleared", {31'd0, err}, 32'd0);
        check("setup_addr", PRWADDR, base);
        while (!done && cycles < 400) begin
            cycles++;
            if (poke_busy && cycles == 3) begin
                start = 1'b1; base_addr = 32'h0000_1000; count = 8'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge PCLK);
        end
        start = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        check("burst_cycles", cycles, exp_cycles);
        check("err_at_finish", {31'd0, err}, {31'd0, timeout});
        @(negedge PCLK);
        #2;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("done_single", {31'd0, done}, 32'd0);
        check("fsm_idle", {30'd0, fsm_state}, 32'd0);
        check("rd_valid_count", rd_valid_cnt - rv0, n_ok);
        check("done_count", done_cnt - dn0, 32'd1);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("addr_q_left", exp_addr_q.size(), {31'd0, timeout});
        check("err_sticky", {31'd0, err}, {31'd0, timeout});
        clear_plan();
    endtask

    task automatic start_zero_count();
        int dn0;
        dn0 = done_cnt;
        @(negedge PCLK);
        start = 1'b1; base_addr = 32'h40; count = 8'd0;
        @(negedge PCLK);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("zero_psel", {31'd0, PSEL}, 32'd0);
            check("zero_busy", {31'd0, busy}, 32'd0);
            @(negedge PCLK);
        end
        #2;
        check("zero_no_done", done_cnt - dn0, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"}, {31'd0, PSEL}, 32'd0);
        check({tag, "_penable"}, {31'd0, PENABLE}, 32'd0);
        check({tag, "_prwaddr"}, PRWADDR, 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'd0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
    endtask

    task automatic reset_mid_burst();
        int exp_cycles, n_ok, setups, rv0, dn0;
        bit timeout;
        model_burst(32'h0, 4, exp_cycles, n_ok, timeout);
        @(negedge PCLK);
        start = 1'b1; base_addr = 32'h0; count = 8'd4;
        @(negedge PCLK);
        start = 1'b0;
        setups = 0;
        for (int g = 0; g < 50 && setups < 3; g++) begin
            if (fsm_state == 2'd1) setups++;
            if (setups < 3) @(negedge PCLK);
        end
        check("rst_reach_setup3", setups, 32'd3);
        @(negedge PCLK);
        check("rst_in_access", {30'd0, fsm_state}, 32'd2);
        PRESET = 1'b0;
        #2;
        rv0 = rd_valid_cnt;
        dn0 = done_cnt;
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge PCLK);
        #2;
        check_all_zero("rst_mid");
        PRESET = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        #2;
        check("rst_no_rd_valid", rd_valid_cnt - rv0, 32'd0);
        check("rst_no_done", done_cnt - dn0, 32'd0);
        check("rst_stays_idle", {31'd0, busy}, 32'd0);
    endtask

    int          rcnt;
    logic [31:0] rbase;

    initial begin
        clear_plan();
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        check_all_zero("reset");
        PRESET = 1'b1;

        slave_write(32'h0, 32'h0000_0309);
        slave_write(32'h4, 32'h2112_2023);
        slave_write(32'h8, 32'h5A48_5552);
        slave_write(32'hC, 32'h4449_4D41);
        run_burst(32'h0, 4, 1'b0);

        waits[1] = 3;
        run_burst(32'h0, 4, 1'b0);

        stall_at = 0;
        run_burst(32'h0, 2, 1'b0);

        slave_write(32'hFFFF_FFFC, 32'hCAFE_F00D);
        run_burst(32'hFFFF_FFFC, 2, 1'b0);

        start_zero_count();
        run_burst(32'h100, 3, 1'b1);

        stall_at = 1;
        waits[0] = 2;
        run_burst(32'h200, 3, 1'b0);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b1;
        #2;
        check("reset_clears_err", {31'd0, err}, 32'd0);

        for (int r = 0; r < 10; r++) begin
            rcnt  = $urandom_range(6, 1);
            rbase = $urandom;
            for (int i = 0; i < rcnt; i++) waits[i] = $urandom_range(3, 0);
            if (r == 6) stall_at = $urandom_range(rcnt - 1, 0);
            run_burst(rbase, rcnt, r[0]);
        end

        reset_mid_burst();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_read_master.md
APB_READ_MASTER -- requirements
Module: apb_read_master

Parameters
REQ-001 The block SHALL have parameter ADDR_STEP, default 4, giving the byte increment between consecutive read addresses.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum ACCESS cycles to wait for PREADY before aborting.

Interface
REQ-003 The block SHALL have port PCLK, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port PRESET, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a burst of reads; sampled in IDLE only.
REQ-006 The block SHALL have port base_addr, input, 32 bits: first read address, captured with start.
REQ-007 The block SHALL have port count, input, 8 bits: number of reads, captured with start.
REQ-008 The block SHALL have port PREADY, input, 1 bit: slave ready.
REQ-009 The block SHALL have port PRDATA1, input, 32 bits: slave read data.
REQ-010 The block SHALL have port PSEL, output, 1 bit: slave select.
REQ-011 The block SHALL have port PENABLE, output, 1 bit: access phase.
REQ-012 The block SHALL have port PWRITE, output, 1 bit: tied to 0 (read only).
REQ-013 The block SHALL have port PRWADDR, output, 32 bits: read address.
REQ-014 The block SHALL have port rd_data, output, 32 bits: last captured read word.
REQ-015 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse when rd_data updates.
REQ-016 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a burst.
REQ-018 The block SHALL have port err, output, 1 bit: sticky timeout flag; cleared by the next accepted start.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, ACCESS and FINISH.
REQ-020 In IDLE, start=1 with count!=0 SHALL capture base_addr into PRWADDR and count into a remaining counter, clear err, and go to SETUP.
REQ-021 In IDLE, start=1 with count=0 SHALL be ignored: no bus activity and no done pulse.
REQ-022 SETUP SHALL last exactly one cycle with PSEL=1, PENABLE=0 and PRWADDR stable, then go to ACCESS.
REQ-023 ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL hold PRWADDR stable until PREADY=1 is sampled.
REQ-024 On PREADY=1 in ACCESS, the block SHALL register PRDATA1 into rd_data, pulse rd_valid in the next cycle, add ADDR_STEP to PRWADDR (modulo 2^32, wrap without flag) and decrement remaining.
REQ-025 After a completed transfer, the FSM SHALL go to SETUP if remaining was greater than 1 (no idle cycle between transfers), otherwise to FINISH.
REQ-026 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-027 When the wait counter reaches TIMEOUT, the block SHALL set err=1, leave rd_valid unasserted and go to FINISH, abandoning the remaining reads.
REQ-028 FINISH SHALL last one cycle with done=1, PSEL=0 and PENABLE=0, then return to IDLE.
REQ-029 start asserted while busy=1 SHALL be ignored.
REQ-030 PENABLE SHALL never be 1 while PSEL=0.
REQ-031 Minimum latency: a zero-wait read SHALL take 2 cycles; a burst of N zero-wait reads SHALL take 2N cycles from SETUP entry to FINISH entry.

Reset
REQ-032 When PRESET=0 at a rising edge, the block SHALL enter IDLE with PSEL, PENABLE, PWRITE, rd_valid, done, err and busy all 0, and PRWADDR, rd_data and remaining all 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst that cycle with no done pulse and no rd_valid pulse; reset SHALL take priority over all other inputs.

Verification
REQ-034 The bench SHALL write 0x00000309, 0x21122023, 0x5A485552 and 0x44494D41 to addresses 0x0, 0x4, 0x8 and 0xC through the existing slave, then start with base_addr=0, count=4 and zero-wait PREADY -> four rd_valid pulses carrying those words in order, done 8 cycles after SETUP entry, err=0.
REQ-035 The bench SHALL hold PREADY low for 3 cycles on the 2nd read -> PRWADDR=0x4 and PSEL/PENABLE held through the wait, correct data captured, burst extended by 3 cycles.
REQ-036 The bench SHALL keep PREADY low permanently with count=2 -> err=1 after 16 ACCESS cycles, no rd_valid, done pulses once, return to IDLE.
REQ-037 The bench SHALL start with base_addr=0xFFFFFFFC and count=2 -> reads at 0xFFFFFFFC then 0x00000000.
REQ-038 The bench SHALL assert start with count=0, and start while busy -> no bus activity for the first; the second is ignored and the original burst completes unchanged.
REQ-039 The bench SHALL drive PRESET=0 during the ACCESS phase of the 3rd read -> next cycle all outputs 0, state IDLE, no done pulse.
